// File: rtl/mem_access_scheduler_if.sv
// rtl/mem_access_scheduler_if.sv - PE requester and memory port bundle for the access scheduler
interface mem_access_scheduler_if #(
    parameter int NUM_REQ    = 5,
    parameter int DATA_WIDTH = 20
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          mem_req_valid;
    logic [DATA_WIDTH-1:0]         mem_req_data;
    logic                          mem_req_ready;
    logic                          mem_rsp_valid;

    // Requesters and memory model side
    modport master (
        output req_valid, req_data, mem_req_ready, mem_rsp_valid,
        input  req_ready, mem_req_valid, mem_req_data
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_data, mem_req_ready, mem_rsp_valid,
        output req_ready, mem_req_valid, mem_req_data
    );
endinterface

// File: rtl/mem_access_scheduler.sv
// rtl/mem_access_scheduler.sv - load-gated round-robin PE packet scheduler into shared CNN memory
module mem_access_scheduler #(
    parameter int NUM_REQ         = 5,
    parameter int DATA_WIDTH      = 20,
    parameter int FILTER_NUM      = 3,
    parameter int IFMAP_NUM       = 5,
    parameter int DEPTH_R         = 3,
    parameter int WIDTH_R         = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    mem_access_scheduler_if.slave      bus,
    input  logic                       i_fload_valid,
    input  logic [7:0]                 i_fload_addr,
    input  logic                       i_mload_valid,
    input  logic [7:0]                 i_mload_addr,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_idx,
    output logic [7:0]                 o_result_count,
    output logic                       o_done,
    output logic                       o_err
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [7:0]       FILTER_LAST   = 8'(FILTER_NUM * FILTER_NUM - 1);
    localparam logic [7:0]       IFMAP_LAST    = 8'(IFMAP_NUM * IFMAP_NUM - 1);
    localparam logic [7:0]       RESULT_TARGET = 8'(DEPTH_R * WIDTH_R);
    localparam logic [OUT_W-1:0] OUT_MAX       = OUT_W'(MAX_OUTSTANDING);
    localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(NUM_REQ - 1);

    localparam logic [1:0] T_RESULT  = 2'b00;
    localparam logic [1:0] T_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        S_LOAD,
        S_ARB,
        S_SEND,
        S_DONE
    } state_t;

    state_t                r_state;
    logic                  r_filter_loaded;
    logic                  r_ifmap_loaded;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic [OUT_W-1:0]      r_outstanding;
    logic                  r_mem_req_valid;
    logic [DATA_WIDTH-1:0] r_mem_req_data;
    logic [IDX_W-1:0]      r_grant_idx;
    logic [7:0]            r_result_count;
    logic                  r_done;
    logic                  r_err;

    logic [NUM_REQ-1:0]    w_elig;
    logic [1:0]            w_req_type;
    logic                  w_pick_valid;
    logic [IDX_W-1:0]      w_pick_idx;
    logic [DATA_WIDTH-1:0] w_pick_data;
    logic [1:0]            w_pick_type;
    logic [NUM_REQ-1:0]    w_req_ready;
    int                    w_cand;
    logic [1:0]            w_send_type;
    logic                  w_fwd;
    logic                  w_fwd_read;
    logic                  w_rsp_ok;
    logic                  w_rsp_orphan;
    logic                  w_illegal_pick;
    logic [7:0]            w_count_next;

    // Eligibility: writes and illegal packets never count against the read window
    always_comb begin
        w_elig     = '0;
        w_req_type = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_req_type = bus.req_data[i*DATA_WIDTH + DATA_WIDTH - 2 +: 2];
            w_elig[i]  = bus.req_valid[i] &&
                         ((w_req_type == T_RESULT) || (w_req_type == T_ILLEGAL) ||
                          (r_outstanding < OUT_MAX));
        end
    end

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_idx   = '0;
        w_cand       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = int'(r_rr_ptr) + k;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_pick_valid && (w_cand == i) && w_elig[i]) begin
                    w_pick_valid = 1'b1;
                    w_pick_idx   = IDX_W'(i);
                end
            end
        end
    end

    // Packet mux and one-hot accept strobe for the picked requester
    always_comb begin
        w_pick_data = '0;
        w_req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick_idx == IDX_W'(i)) begin
                w_pick_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
            w_req_ready[i] = (r_state == S_ARB) && w_pick_valid && (w_pick_idx == IDX_W'(i));
        end
    end

    assign w_pick_type    = w_pick_data[DATA_WIDTH-1 -: 2];
    assign w_send_type    = r_mem_req_data[DATA_WIDTH-1 -: 2];
    assign w_fwd          = (r_state == S_SEND) && bus.mem_req_ready;
    assign w_fwd_read     = w_fwd && (w_send_type != T_RESULT);
    assign w_rsp_ok       = bus.mem_rsp_valid && (r_outstanding != '0);
    assign w_rsp_orphan   = bus.mem_rsp_valid && (r_outstanding == '0);
    assign w_illegal_pick = (r_state == S_ARB) && w_pick_valid && (w_pick_type == T_ILLEGAL);
    assign w_count_next   = r_result_count + 8'd1;

    // Scheduler FSM with load tracking, read window and result counting
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= S_LOAD;
            r_filter_loaded <= 1'b0;
            r_ifmap_loaded  <= 1'b0;
            r_rr_ptr        <= '0;
            r_outstanding   <= '0;
            r_mem_req_valid <= 1'b0;
            r_mem_req_data  <= '0;
            r_grant_idx     <= '0;
            r_result_count  <= '0;
            r_done          <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            if (i_fload_valid && (i_fload_addr == FILTER_LAST)) begin
                r_filter_loaded <= 1'b1;
            end
            if (i_mload_valid && (i_mload_addr == IFMAP_LAST)) begin
                r_ifmap_loaded <= 1'b1;
            end

            r_err <= w_illegal_pick || w_rsp_orphan;

            // A forward and a response in the same cycle cancel out
            case ({w_fwd_read, w_rsp_ok})
                2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase

            case (r_state)
                S_LOAD: begin
                    if (r_filter_loaded && r_ifmap_loaded) begin
                        r_state <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (w_pick_valid) begin
                        r_mem_req_data <= w_pick_data;
                        r_grant_idx    <= w_pick_idx;
                        r_rr_ptr       <= (w_pick_idx == LAST_IDX) ? '0 : w_pick_idx + IDX_W'(1);
                        // Illegal packets are swallowed here and never reach memory
                        if (w_pick_type != T_ILLEGAL) begin
                            r_mem_req_valid <= 1'b1;
                            r_state         <= S_SEND;
                        end
                    end
                end
                S_SEND: begin
                    if (bus.mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= S_ARB;
                        if (w_send_type == T_RESULT) begin
                            r_result_count <= w_count_next;
                            if (w_count_next == RESULT_TARGET) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_done <= 1'b1;
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign bus.req_ready     = w_req_ready;
    assign bus.mem_req_valid = r_mem_req_valid;
    assign bus.mem_req_data  = r_mem_req_data;
    assign o_grant_idx       = r_grant_idx;
    assign o_result_count    = r_result_count;
    assign o_done            = r_done;
    assign o_err             = r_err;
endmodule

// File: tb/tb_mem_access_scheduler.sv
// tb/tb_mem_access_scheduler.sv - scoreboard bench for mem_access_scheduler
module tb_mem_access_scheduler;
    localparam int NR = 5;
    localparam int DW = 20;
    localparam logic [1:0] T_RES = 2'b00;
    localparam logic [1:0] T_IFM = 2'b01;
    localparam logic [1:0] T_FLT = 2'b10;
    localparam logic [1:0] T_ILL = 2'b11;

    logic       clk;
    logic       rst_n;
    logic       fload_valid;
    logic [7:0] fload_addr;
    logic       mload_valid;
    logic [7:0] mload_addr;
    logic [2:0] grant_idx;
    logic [7:0] result_count;
    logic       done;
    logic       err;

    mem_access_scheduler_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    mem_access_scheduler dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .bus            (bus),
        .i_fload_valid  (fload_valid),
        .i_fload_addr   (fload_addr),
        .i_mload_valid  (mload_valid),
        .i_mload_addr   (mload_addr),
        .o_grant_idx    (grant_idx),
        .o_result_count (result_count),
        .o_done         (done),
        .o_err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int              n_checks = 0;
    int              n_pass   = 0;
    int              exp_grant[$];
    int              exp_gidx[$];
    logic [DW-1:0]   exp_data[$];
    logic [NR-1:0]   last_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [DW-1:0] mk_pkt(input logic [1:0] t, input int p);
        logic [17:0] pl;
        pl = p[17:0];
        return {t, pl};
    endfunction

    task automatic set_req(input int i, input logic [DW-1:0] d);
        bus.req_data[i*DW +: DW] = d;
        bus.req_valid[i]         = 1'b1;
    endtask

    task automatic expect_fwd(input int i, input logic [DW-1:0] d);
        exp_grant.push_back(i);
        exp_gidx.push_back(i);
        exp_data.push_back(d);
    endtask

    // One clock: score grants and handshakes at negedge, retire accepted requests after posedge
    task automatic cycle();
        int            e;
        logic [NR-1:0] oh;
        @(negedge clk);
        if (bus.req_ready != '0) begin
            if (exp_grant.size() == 0) check("unexpected_grant", exp_grant.size(), 1);
            else begin
                e  = exp_grant.pop_front();
                oh = NR'(1) << e;
                check("grant_onehot", bus.req_ready, oh);
            end
        end
        if (bus.mem_req_valid && bus.mem_req_ready) begin
            if (exp_data.size() == 0) check("unexpected_fwd", exp_data.size(), 1);
            else begin
                check("fwd_data", bus.mem_req_data, exp_data.pop_front());
                check("fwd_grant_idx", grant_idx, exp_gidx.pop_front());
            end
        end
        last_acc = bus.req_ready;
        @(posedge clk);
        #1;
        bus.req_valid = bus.req_valid & ~last_acc;
    endtask

    task automatic cycles(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    task automatic wait_grant(input int i);
        int seen;
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            cycle();
            if (last_acc[i]) seen = 1;
        end
        check("wait_grant", seen, 1);
    endtask

    task automatic rsp_pulse();
        bus.mem_rsp_valid = 1'b1;
        cycle();
        bus.mem_rsp_valid = 1'b0;
    endtask

    task automatic do_loads();
        fload_valid = 1'b1; fload_addr = 8'd8;
        mload_valid = 1'b1; mload_addr = 8'd24;
        cycle();
        fload_valid = 1'b0; mload_valid = 1'b0;
    endtask

    task automatic check_queues_empty(input string tag);
        check(tag, exp_grant.size() + exp_data.size(), 0);
    endtask

    initial begin
        rst_n             = 1'b0;
        fload_valid       = 1'b0; fload_addr = '0;
        mload_valid       = 1'b0; mload_addr = '0;
        bus.req_valid     = '0;
        bus.req_data      = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        last_acc          = '0;
        cycles(3);

        check("rst_req_ready", bus.req_ready, 0);
        check("rst_mem_valid", bus.mem_req_valid, 0);
        check("rst_mem_data", bus.mem_req_data, 0);
        check("rst_grant_idx", grant_idx, 0);
        check("rst_result_count", result_count, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;

        // Requests before images are loaded must be held off
        for (int i = 0; i < NR; i++) set_req(i, mk_pkt(T_IFM, 16'h100 + i));
        bus.mem_req_ready = 1'b1;
        cycles(4);
        fload_valid = 1'b1; fload_addr = 8'd7;
        cycle();
        fload_addr = 8'd8;
        cycle();
        fload_valid = 1'b0;
        cycles(2);
        check("no_ready_filter_only", bus.req_ready, 0);
        mload_valid = 1'b1; mload_addr = 8'd24;
        cycle();
        mload_valid = 1'b0;
        check("ready_flag_cycle", bus.req_ready, 0);
        for (int i = 0; i < 4; i++) expect_fwd(i, mk_pkt(T_IFM, 16'h100 + i));
        cycle();
        check("first_grant_latency", bus.req_ready, 5'b00001);

        // Read window fills at 4; requester 4 stalls until a response
        cycles(12);
        check_queues_empty("rr_0to3_done");
        check("stall_at_max", bus.req_ready, 0);
        check("stall_no_valid", bus.mem_req_valid, 0);
        expect_fwd(4, mk_pkt(T_IFM, 16'h104));
        rsp_pulse();
        cycles(5);
        check_queues_empty("req4_after_rsp");

        for (int i = 0; i < 4; i++) rsp_pulse();
        check("err_quiet_drain", err, 0);
        rsp_pulse();
        check("err_orphan_rsp", err, 1);
        cycle();
        check("err_one_cycle", err, 0);

        // Backpressure holds SEND with stable data
        bus.mem_req_ready = 1'b0;
        set_req(0, mk_pkt(T_FLT, 16'h2a5));
        set_req(1, mk_pkt(T_IFM, 16'h3c3));
        expect_fwd(0, mk_pkt(T_FLT, 16'h2a5));
        expect_fwd(1, mk_pkt(T_IFM, 16'h3c3));
        wait_grant(0);
        for (int c = 0; c < 10; c++) begin
            check("bp_valid", bus.mem_req_valid, 1);
            check("bp_data", bus.mem_req_data, mk_pkt(T_FLT, 16'h2a5));
            check("bp_no_ready", bus.req_ready, 0);
            cycle();
        end
        bus.mem_req_ready = 1'b1;
        cycle();
        check("bp_release_1cyc", bus.mem_req_valid, 0);
        wait_grant(1);
        cycles(2);
        check_queues_empty("bp_done");
        rsp_pulse();
        rsp_pulse();

        // Illegal packet is accepted, dropped and flagged; rr moves past it
        set_req(1, mk_pkt(T_ILL, 16'h0ee));
        exp_grant.push_back(1);
        wait_grant(1);
        check("ill_err", err, 1);
        check("ill_not_fwd", bus.mem_req_valid, 0);
        set_req(2, mk_pkt(T_IFM, 16'h022));
        set_req(0, mk_pkt(T_IFM, 16'h020));
        expect_fwd(2, mk_pkt(T_IFM, 16'h022));
        expect_fwd(0, mk_pkt(T_IFM, 16'h020));
        cycle();
        check("ill_err_pulse", err, 0);
        cycles(5);
        check_queues_empty("ill_next_grants");
        rsp_pulse();
        rsp_pulse();

        // Nine result writes raise done; the tenth is never accepted
        for (int n = 0; n < 9; n++) begin
            set_req(3, mk_pkt(T_RES, 16'h200 + n));
            expect_fwd(3, mk_pkt(T_RES, 16'h200 + n));
            wait_grant(3);
            cycle();
            check("result_count", result_count, n + 1);
            check("done_flag", done, (n == 8) ? 1 : 0);
        end
        set_req(3, mk_pkt(T_RES, 16'h2ff));
        cycles(10);
        check("done_no_ready", bus.req_ready, 0);
        check("done_sticky", done, 1);
        check("done_no_valid", bus.mem_req_valid, 0);
        check_queues_empty("results_done");

        // Asynchronous reset in SEND with three reads outstanding
        rst_n = 1'b0;
        bus.req_valid = '0;
        cycle();
        rst_n = 1'b1;
        do_loads();
        bus.mem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_req(i, mk_pkt(T_IFM, 16'h300 + i));
            expect_fwd(i, mk_pkt(T_IFM, 16'h300 + i));
        end
        cycles(8);
        check_queues_empty("pre_reset_reads");
        bus.mem_req_ready = 1'b0;
        set_req(3, mk_pkt(T_FLT, 16'h333));
        exp_grant.push_back(3);
        wait_grant(3);
        check("pre_reset_send", bus.mem_req_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mem_valid", bus.mem_req_valid, 0);
        check("arst_mem_data", bus.mem_req_data, 0);
        check("arst_grant_idx", grant_idx, 0);
        check("arst_result_count", result_count, 0);
        check("arst_done", done, 0);
        check("arst_req_ready", bus.req_ready, 0);
        exp_grant.delete();
        exp_gidx.delete();
        exp_data.delete();
        cycle();
        rst_n = 1'b1;
        bus.req_valid = '0;
        bus.mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, mk_pkt(T_IFM, 16'h340 + i));
        cycles(5);
        check("reload_required", bus.req_ready, 0);
        for (int i = 0; i < 4; i++) expect_fwd(i, mk_pkt(T_IFM, 16'h340 + i));
        do_loads();
        cycles(14);
        check_queues_empty("outstanding_cleared");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
